// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_ctrl_unit slice: widths, opcodes, FSM states
// and instruction field helpers.
package cpu_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned INSTR_W = 8;
  localparam int unsigned REG_AW  = 2;

  localparam int unsigned OP_LSB  = 6;
  localparam int unsigned RS_LSB  = 4;
  localparam int unsigned RT_LSB  = 2;
  localparam int unsigned RD_LSB  = 0;
  localparam int unsigned JOFF_W  = 6;
  localparam int unsigned IMM_W   = 2;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADDI = 2'b10,
    OP_J    = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  function automatic op_e instr_op(input logic [INSTR_W-1:0] i);
    return op_e'(i[OP_LSB +: 2]);
  endfunction

  function automatic logic [REG_AW-1:0] instr_rs(input logic [INSTR_W-1:0] i);
    return i[RS_LSB +: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] instr_rt(input logic [INSTR_W-1:0] i);
    return i[RT_LSB +: REG_AW];
  endfunction

  function automatic logic [REG_AW-1:0] instr_rd(input logic [INSTR_W-1:0] i);
    return i[RD_LSB +: REG_AW];
  endfunction

  function automatic logic [DATA_W-1:0] imm_sext(input logic [INSTR_W-1:0] i);
    return {{(DATA_W-IMM_W){i[RD_LSB+IMM_W-1]}}, i[RD_LSB +: IMM_W]};
  endfunction

  function automatic logic [PC_W-1:0] joff_sext(input logic [INSTR_W-1:0] i);
    return {{(PC_W-JOFF_W){i[JOFF_W-1]}}, i[0 +: JOFF_W]};
  endfunction

endpackage

// File: rtl/cpu_ctrl_unit_if.sv
// Instruction-fetch and register-file port bundle between the controller
// (master) and the memory / register file side (slave).
interface cpu_ctrl_unit_if;
  import cpu_pkg::*;

  logic                 imem_req;
  logic [PC_W-1:0]      imem_addr;
  logic                 imem_valid;
  logic [INSTR_W-1:0]   imem_data;

  logic [REG_AW-1:0]    Read_Register1;
  logic [REG_AW-1:0]    Read_Register2;
  logic [DATA_W-1:0]    Read_Data1;
  logic [DATA_W-1:0]    Read_Data2;
  logic [REG_AW-1:0]    Write_Register;
  logic                 RegWrite;
  logic [DATA_W-1:0]    Write_Data;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_data,
    output Read_Register1, Read_Register2,
    input  Read_Data1, Read_Data2,
    output Write_Register, RegWrite, Write_Data
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_data,
    input  Read_Register1, Read_Register2,
    output Read_Data1, Read_Data2,
    input  Write_Register, RegWrite, Write_Data
  );

endinterface

// File: rtl/alu8.sv
// Combinational 8-bit ALU: add for ADD/ADDI, subtract for SUB, modulo 2^DATA_W.
module alu8
  import cpu_pkg::*;
(
  input  op_e               i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y
);

  always_comb begin
    o_y = i_a + i_b;
    if (i_op == OP_SUB) o_y = i_a - i_b;
  end

endmodule

// File: rtl/cpu_ctrl_unit.sv
// Multi-cycle fetch/decode/execute/write-back controller driving a 4x8
// register file; supports free-running (run) and single-step execution.
module cpu_ctrl_unit
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  cpu_ctrl_unit_if.master   bus,
  output logic [PC_W-1:0]   pc,
  output logic              instr_done,
  output logic              halted
);

  state_e              r_state;
  logic [PC_W-1:0]     r_pc;
  logic [INSTR_W-1:0]  r_instr;
  logic [DATA_W-1:0]   r_alu_q;
  logic                r_imem_req;
  logic                r_reg_write;
  logic [REG_AW-1:0]   r_wr_reg;
  logic                r_instr_done;
  logic                r_halted;

  op_e                 w_op;
  logic [DATA_W-1:0]   w_alu_b;
  logic [DATA_W-1:0]   w_alu_y;

  assign w_op    = instr_op(r_instr);
  assign w_alu_b = (w_op == OP_ADDI) ? imm_sext(r_instr) : bus.Read_Data2;

  alu8 u_alu (
    .i_op (w_op),
    .i_a  (bus.Read_Data1),
    .i_b  (w_alu_b),
    .o_y  (w_alu_y)
  );

  // Read addresses follow the latched instruction, so they hold between instructions.
  assign bus.Read_Register1 = instr_rs(r_instr);
  assign bus.Read_Register2 = instr_rt(r_instr);
  assign bus.imem_req       = r_imem_req;
  assign bus.imem_addr      = r_pc;
  assign bus.Write_Register = r_wr_reg;
  assign bus.RegWrite       = r_reg_write;
  assign bus.Write_Data     = r_alu_q;
  assign pc                 = r_pc;
  assign instr_done         = r_instr_done;
  assign halted             = r_halted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_pc         <= '0;
      r_instr      <= '0;
      r_alu_q      <= '0;
      r_imem_req   <= 1'b0;
      r_reg_write  <= 1'b0;
      r_wr_reg     <= '0;
      r_instr_done <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_reg_write  <= 1'b0;
      r_instr_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (run || step) begin
            r_state    <= ST_FETCH;
            r_imem_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (bus.imem_valid) begin
            r_instr    <= bus.imem_data;
            r_imem_req <= 1'b0;
            r_state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_alu_q <= w_alu_y;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (w_op == OP_J) begin
            // A zero jump offset is the HALT encoding.
            if (r_instr[0 +: JOFF_W] == '0) begin
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end else begin
              r_pc         <= r_pc + joff_sext(r_instr);
              r_instr_done <= 1'b1;
              r_state      <= ST_WB;
            end
          end else begin
            r_pc         <= r_pc + PC_W'(1);
            r_reg_write  <= 1'b1;
            r_wr_reg     <= (w_op == OP_ADDI) ? instr_rt(r_instr) : instr_rd(r_instr);
            r_instr_done <= 1'b1;
            r_state      <= ST_WB;
          end
        end
        ST_WB: begin
          if (run) begin
            r_imem_req <= 1'b1;
            r_state    <= ST_FETCH;
          end else begin
            r_state    <= ST_IDLE;
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_unit.sv
// Scoreboard bench for cpu_ctrl_unit with a behavioural register file and
// instruction memory of configurable latency.
module tb_cpu_ctrl_unit;
  import cpu_pkg::*;

  localparam int unsigned CLK_HALF = 5;

  typedef struct {
    logic       wr;
    logic [1:0] wreg;
    logic [7:0] wdata;
    logic [7:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic run;
  logic step;
  logic [PC_W-1:0] pc;
  logic instr_done;
  logic halted;

  cpu_ctrl_unit_if bus ();

  cpu_ctrl_unit dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .bus        (bus),
    .pc         (pc),
    .instr_done (instr_done),
    .halted     (halted)
  );

  always #CLK_HALF clk = ~clk;

  int checks = 0;
  int errors = 0;
  int retired = 0;
  int req_seen = 0;
  int lat = 0;
  int wait_cnt = 0;
  exp_t sb[$];
  logic [7:0] rf [4];
  logic [7:0] mem [256];
  logic       prev_req = 1'b0;
  logic [7:0] held_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Register file: combinational read, write on the clock edge.
  assign bus.Read_Data1 = rf[bus.Read_Register1];
  assign bus.Read_Data2 = rf[bus.Read_Register2];
  always @(posedge clk) if (!reset && bus.RegWrite) rf[bus.Write_Register] <= bus.Write_Data;

  // Instruction memory answers after lat wait cycles, one-cycle valid.
  initial begin bus.imem_valid = 1'b0; bus.imem_data = '0; end
  always @(negedge clk) begin
    if (bus.imem_valid) begin
      bus.imem_valid = 1'b0;
    end else if (bus.imem_req) begin
      if (wait_cnt >= lat) begin
        bus.imem_valid = 1'b1;
        bus.imem_data  = mem[bus.imem_addr];
        wait_cnt       = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Monitor: retirement scoreboard plus fetch-address stability.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.imem_req) req_seen++;
      if (bus.imem_req && prev_req) check("imem_addr_held", bus.imem_addr, held_addr);
      prev_req  = bus.imem_req;
      held_addr = bus.imem_addr;
      if (instr_done) begin
        retired++;
        if (sb.size() == 0) begin
          check("unexpected_retire", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("wb_regwrite", bus.RegWrite, e.wr);
          check("wb_pc", pc, e.pc);
          if (e.wr) begin
            check("wb_reg", bus.Write_Register, e.wreg);
            check("wb_data", bus.Write_Data, e.wdata);
          end
        end
      end else if (bus.RegWrite) begin
        check("regwrite_outside_wb", 1, 0);
      end
    end else begin
      prev_req = 1'b0;
    end
  end

  task automatic push(input logic wr, input logic [1:0] r, input logic [7:0] d, input logic [7:0] p);
    exp_t e;
    e.wr = wr; e.wreg = r; e.wdata = d; e.pc = p;
    sb.push_back(e);
  endtask

  task automatic wait_retired(input int target, input int budget);
    int n = 0;
    while (retired < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("retire_count", retired, target);
  endtask

  task automatic pulse_step();
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; run = 1'b0; step = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
    rf[0] = 8'h00; rf[1] = 8'h00; rf[2] = 8'hFF; rf[3] = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_pc", pc, 0);
    check("rst_regwrite", bus.RegWrite, 0);
    check("rst_instr_done", instr_done, 0);
    check("rst_halted", halted, 0);

    // Reset while FETCH is waiting on a memory that never answers.
    lat = 1000;
    reset = 1'b0; run = 1'b1;
    repeat (4) @(negedge clk);
    check("fetch_req_pending", bus.imem_req, 1);
    #2 reset = 1'b1;
    #1;
    check("midfetch_imem_req", bus.imem_req, 0);
    check("midfetch_pc", pc, 0);
    check("midfetch_regwrite", bus.RegWrite, 0);
    check("midfetch_halted", halted, 0);
    run = 1'b0;
    repeat (2) @(negedge clk);

    // Free-running program ending in HALT.
    mem[0] = 8'h85;  // ADDI r1 = r0 + 1
    mem[1] = 8'hC2;  // J +2 -> 3
    mem[2] = 8'hC0;  // HALT
    mem[3] = 8'h1B;  // ADD r3 = r1 + r2
    mem[4] = 8'h44;  // SUB r0 = r0 - r1
    mem[5] = 8'hFD;  // J -3 -> 2
    push(1, 2'd1, 8'h01, 8'h01);
    push(0, 2'd0, 8'h00, 8'h03);
    push(1, 2'd3, 8'h00, 8'h04);
    push(1, 2'd0, 8'hFF, 8'h05);
    push(0, 2'd0, 8'h00, 8'h02);
    lat = 0; retired = 0;
    reset = 1'b0; run = 1'b1;
    n = 0;
    while (!halted && n < 300) begin @(negedge clk); n++; end
    check("halted", halted, 1);
    check("halt_pc", pc, 2);
    check("prog_retired", retired, 5);
    req_seen = 0;
    repeat (10) @(negedge clk);
    check("no_req_after_halt", req_seen, 0);
    check("rf_r0", rf[0], 8'hFF);
    check("rf_r1", rf[1], 8'h01);
    check("rf_r2", rf[2], 8'hFF);
    check("rf_r3", rf[3], 8'h00);
    check("sb_empty_run", sb.size(), 0);
    run = 1'b0;

    // Single-step with slow memory; step during FETCH must be ignored.
    reset = 1'b1;
    @(negedge clk);
    check("halt_cleared", halted, 0);
    mem[0] = 8'h9A;  // ADDI r2 = r1 + (-2)
    mem[1] = 8'h44;  // SUB r0 = r0 - r1
    rf[0] = 8'h10; rf[1] = 8'h05; rf[2] = 8'h00; rf[3] = 8'h00;
    lat = 3; retired = 0;
    @(negedge clk); reset = 1'b0;
    push(1, 2'd2, 8'h03, 8'h01);
    pulse_step();
    pulse_step();
    wait_retired(1, 60);
    req_seen = 0;
    repeat (20) @(negedge clk);
    check("step_one_retire", retired, 1);
    check("step_idle_no_req", req_seen, 0);
    check("step_pc", pc, 1);
    push(1, 2'd0, 8'h0B, 8'h02);
    pulse_step();
    wait_retired(2, 60);
    repeat (5) @(negedge clk);
    check("rf_step_r2", rf[2], 8'h03);
    check("rf_step_r0", rf[0], 8'h0B);
    check("sb_empty_step", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
